// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared types and defaults for the ID/EX pipeline register
package id_ex_stage_pkg;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b100,
    ALU_MUL = 3'b101,
    ALU_SLT = 3'b110
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

  // Decoded control carried through the EX stage; zero is a bubble.
  typedef struct packed {
    logic    reg_write;
    logic    memto_reg;
    logic    mem_write;
    logic    alu_src;
    logic    reg_dst;
    alu_op_e alu_ctl;
  } ex_ctrl_t;

  function automatic logic dest_hits(input logic        wr_en,
                                     input logic [31:0] dest,
                                     input logic [31:0] src);
    return wr_en && (dest != 32'd0) && (dest == src);
  endfunction

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// rtl/id_ex_stage_forward_unit.sv - picks the freshest source for one EX operand
module forward_unit
  import id_ex_stage_pkg::*;
#(
  parameter int addr_w = ADDR_W
) (
  input  logic [addr_w-1:0] src_i,
  input  logic [addr_w-1:0] write_reg_m_i,
  input  logic              reg_write_m_i,
  input  logic [addr_w-1:0] write_reg_w_i,
  input  logic              reg_write_w_i,
  output fwd_sel_e          fwd_sel_o
);

  logic [31:0] src_ext;
  logic [31:0] dest_m_ext;
  logic [31:0] dest_w_ext;

  assign src_ext    = 32'(src_i);
  assign dest_m_ext = 32'(write_reg_m_i);
  assign dest_w_ext = 32'(write_reg_w_i);

  // MEM holds the younger result, so it is checked first.
  always_comb begin
    fwd_sel_o = FWD_RF;
    if (dest_hits(reg_write_m_i, dest_m_ext, src_ext)) begin
      fwd_sel_o = FWD_MEM;
    end else if (dest_hits(reg_write_w_i, dest_w_ext, src_ext)) begin
      fwd_sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use detection
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int width  = WIDTH,
  parameter int addr_w = ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall_E,
  input  logic              Flush_E,
  input  logic              Valid_D,
  input  logic [width-1:0]  RD1_D,
  input  logic [width-1:0]  RD2_D,
  input  logic [width-1:0]  SignImm_D,
  input  logic [addr_w-1:0] Rs_D,
  input  logic [addr_w-1:0] Rt_D,
  input  logic [addr_w-1:0] Rd_D,
  input  logic              RegWrite_D,
  input  logic              MemtoReg_D,
  input  logic              MemWrite_D,
  input  logic              ALUSrc_D,
  input  logic              RegDst_D,
  input  logic [2:0]        Alu_Control_D,
  input  logic [width-1:0]  ALUOut_M,
  input  logic [addr_w-1:0] WriteReg_M,
  input  logic              RegWrite_M,
  input  logic [width-1:0]  Result_W,
  input  logic [addr_w-1:0] WriteReg_W,
  input  logic              RegWrite_W,
  output logic [width-1:0]  ScrA,
  output logic [width-1:0]  ScrB,
  output logic [2:0]        Alu_Control,
  output logic [width-1:0]  WriteData_E,
  output logic [addr_w-1:0] WriteReg_E,
  output logic              RegWrite_E,
  output logic              MemtoReg_E,
  output logic              MemWrite_E,
  output logic              Valid_E,
  output logic              LoadUse_Stall
);

  logic              valid_q, valid_d;
  logic [width-1:0]  rd1_q, rd1_d;
  logic [width-1:0]  rd2_q, rd2_d;
  logic [width-1:0]  imm_q, imm_d;
  logic [addr_w-1:0] rs_q, rs_d;
  logic [addr_w-1:0] rt_q, rt_d;
  logic [addr_w-1:0] rd_q, rd_d;
  ex_ctrl_t          ctrl_q, ctrl_d;
  ex_ctrl_t          ctrl_in;

  fwd_sel_e          fwd_a;
  fwd_sel_e          fwd_b;
  logic [width-1:0]  opnd_a;
  logic [width-1:0]  opnd_b;

  assign ctrl_in = '{
    reg_write: RegWrite_D,
    memto_reg: MemtoReg_D,
    mem_write: MemWrite_D,
    alu_src:   ALUSrc_D,
    reg_dst:   RegDst_D,
    alu_ctl:   alu_op_e'(Alu_Control_D)
  };

  // Flush beats stall; a non-valid decode slot still latches data but no control.
  always_comb begin
    valid_d = valid_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    if (Flush_E) begin
      valid_d = 1'b0;
      rd1_d   = '0;
      rd2_d   = '0;
      imm_d   = '0;
      rs_d    = '0;
      rt_d    = '0;
      rd_d    = '0;
      ctrl_d  = '0;
    end else if (!Stall_E) begin
      valid_d = Valid_D;
      rd1_d   = RD1_D;
      rd2_d   = RD2_D;
      imm_d   = SignImm_D;
      rs_d    = Rs_D;
      rt_d    = Rt_D;
      rd_d    = Rd_D;
      ctrl_d  = Valid_D ? ctrl_in : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
    end
  end

  forward_unit #(.addr_w(addr_w)) u_fwd_a (
    .src_i         (rs_q),
    .write_reg_m_i (WriteReg_M),
    .reg_write_m_i (RegWrite_M),
    .write_reg_w_i (WriteReg_W),
    .reg_write_w_i (RegWrite_W),
    .fwd_sel_o     (fwd_a)
  );

  forward_unit #(.addr_w(addr_w)) u_fwd_b (
    .src_i         (rt_q),
    .write_reg_m_i (WriteReg_M),
    .reg_write_m_i (RegWrite_M),
    .write_reg_w_i (WriteReg_W),
    .reg_write_w_i (RegWrite_W),
    .fwd_sel_o     (fwd_b)
  );

  always_comb begin
    case (fwd_a)
      FWD_MEM: opnd_a = ALUOut_M;
      FWD_WB:  opnd_a = Result_W;
      default: opnd_a = rd1_q;
    endcase
    case (fwd_b)
      FWD_MEM: opnd_b = ALUOut_M;
      FWD_WB:  opnd_b = Result_W;
      default: opnd_b = rd2_q;
    endcase
  end

  assign ScrA        = opnd_a;
  assign ScrB        = ctrl_q.alu_src ? imm_q : opnd_b;
  assign WriteData_E = opnd_b;
  assign Alu_Control = ctrl_q.alu_ctl;
  assign WriteReg_E  = ctrl_q.reg_dst ? rd_q : rt_q;
  assign Valid_E     = valid_q;
  assign RegWrite_E  = valid_q & ctrl_q.reg_write;
  assign MemtoReg_E  = valid_q & ctrl_q.memto_reg;
  assign MemWrite_E  = valid_q & ctrl_q.mem_write;

  // Rt_E of zero still stalls; the hazard unit turns this into flush + upstream stall.
  assign LoadUse_Stall = Valid_E && MemtoReg_E && Valid_D &&
                         ((rt_q == Rs_D) || (rt_q == Rt_D));

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        Stall_E, Flush_E, Valid_D;
  logic [31:0] RD1_D, RD2_D, SignImm_D;
  logic [4:0]  Rs_D, Rt_D, Rd_D;
  logic        RegWrite_D, MemtoReg_D, MemWrite_D, ALUSrc_D, RegDst_D;
  logic [2:0]  Alu_Control_D;
  logic [31:0] ALUOut_M;
  logic [4:0]  WriteReg_M;
  logic        RegWrite_M;
  logic [31:0] Result_W;
  logic [4:0]  WriteReg_W;
  logic        RegWrite_W;
  logic [31:0] ScrA, ScrB, WriteData_E;
  logic [2:0]  Alu_Control;
  logic [4:0]  WriteReg_E;
  logic        RegWrite_E, MemtoReg_E, MemWrite_E, Valid_E, LoadUse_Stall;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .Stall_E(Stall_E), .Flush_E(Flush_E), .Valid_D(Valid_D),
    .RD1_D(RD1_D), .RD2_D(RD2_D), .SignImm_D(SignImm_D),
    .Rs_D(Rs_D), .Rt_D(Rt_D), .Rd_D(Rd_D),
    .RegWrite_D(RegWrite_D), .MemtoReg_D(MemtoReg_D), .MemWrite_D(MemWrite_D),
    .ALUSrc_D(ALUSrc_D), .RegDst_D(RegDst_D), .Alu_Control_D(Alu_Control_D),
    .ALUOut_M(ALUOut_M), .WriteReg_M(WriteReg_M), .RegWrite_M(RegWrite_M),
    .Result_W(Result_W), .WriteReg_W(WriteReg_W), .RegWrite_W(RegWrite_W),
    .ScrA(ScrA), .ScrB(ScrB), .Alu_Control(Alu_Control), .WriteData_E(WriteData_E),
    .WriteReg_E(WriteReg_E), .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E),
    .MemWrite_E(MemWrite_E), .Valid_E(Valid_E), .LoadUse_Stall(LoadUse_Stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_mw();
    ALUOut_M = 32'h0; WriteReg_M = 5'd0; RegWrite_M = 1'b0;
    Result_W = 32'h0; WriteReg_W = 5'd0; RegWrite_W = 1'b0;
  endtask

  initial begin
    rst = 1'b1; Stall_E = 1'b0; Flush_E = 1'b0; Valid_D = 1'b1;
    RD1_D = 32'hDEAD0001; RD2_D = 32'hDEAD0002; SignImm_D = 32'h1234;
    Rs_D = 5'd7; Rt_D = 5'd8; Rd_D = 5'd9;
    RegWrite_D = 1'b1; MemtoReg_D = 1'b1; MemWrite_D = 1'b1; ALUSrc_D = 1'b0; RegDst_D = 1'b1;
    Alu_Control_D = 3'b110;
    clear_mw();

    // reset with busy decode inputs
    tick(); tick();
    check("rst_valid",    32'(Valid_E), 32'd0);
    check("rst_aluctl",   32'(Alu_Control), 32'd0);
    check("rst_regwrite", 32'(RegWrite_E), 32'd0);
    check("rst_memtoreg", 32'(MemtoReg_E), 32'd0);
    check("rst_writereg", 32'(WriteReg_E), 32'd0);
    check("rst_loaduse",  32'(LoadUse_Stall), 32'd0);

    // plain load
    rst = 1'b0;
    RD1_D = 32'd5; RD2_D = 32'd7; Alu_Control_D = 3'b010; ALUSrc_D = 1'b0; RegDst_D = 1'b1;
    Rs_D = 5'd1; Rt_D = 5'd2; Rd_D = 5'd9; MemtoReg_D = 1'b0; MemWrite_D = 1'b0;
    tick();
    check("load_scra",    ScrA, 32'd5);
    check("load_scrb",    ScrB, 32'd7);
    check("load_aluctl",  32'(Alu_Control), 32'b010);
    check("load_wreg",    32'(WriteReg_E), 32'd9);
    check("load_valid",   32'(Valid_E), 32'd1);
    check("load_regwr",   32'(RegWrite_E), 32'd1);
    check("load_wdata",   WriteData_E, 32'd7);

    // forwarding priority on A, then B
    Rs_D = 5'd3; RD1_D = 32'h33; Rt_D = 5'd2; RD2_D = 32'h44; RegDst_D = 1'b0;
    tick();
    check("rt_dest", 32'(WriteReg_E), 32'd2);
    RegWrite_M = 1'b1; WriteReg_M = 5'd3; ALUOut_M = 32'h11;
    RegWrite_W = 1'b1; WriteReg_W = 5'd3; Result_W = 32'h22;
    settle();
    check("fwd_mem_wins", ScrA, 32'h11);
    RegWrite_M = 1'b0;
    settle();
    check("fwd_wb", ScrA, 32'h22);
    RegWrite_M = 1'b1; WriteReg_M = 5'd0; WriteReg_W = 5'd7;
    settle();
    check("fwd_r0_none", ScrA, 32'h33);
    check("fwd_b_none",  ScrB, 32'h44);
    WriteReg_M = 5'd2;
    settle();
    check("fwd_b_mem",   ScrB, 32'h11);
    check("fwd_b_wdata", WriteData_E, 32'h11);
    clear_mw();

    // immediate operand with forwarded store data
    ALUSrc_D = 1'b1; SignImm_D = 32'hFFFFFFFC; Rt_D = 5'd6; RD2_D = 32'h66;
    MemWrite_D = 1'b1;
    tick();
    RegWrite_W = 1'b1; WriteReg_W = 5'd6; Result_W = 32'h40;
    settle();
    check("imm_scrb",   ScrB, 32'hFFFFFFFC);
    check("imm_wdata",  WriteData_E, 32'h40);
    check("imm_memwr",  32'(MemWrite_E), 32'd1);
    clear_mw();

    // stall holds, flush beats stall
    ALUSrc_D = 1'b0; Rs_D = 5'd1; Rt_D = 5'd2; Rd_D = 5'd3; RD1_D = 32'hA1; RD2_D = 32'hA2;
    Alu_Control_D = 3'b001; RegDst_D = 1'b1; RegWrite_D = 1'b1; MemWrite_D = 1'b1;
    tick();
    RD1_D = 32'hB1; Alu_Control_D = 3'b100; Rd_D = 5'd8; MemWrite_D = 1'b0;
    Stall_E = 1'b1;
    tick(); tick();
    check("stall_scra",   ScrA, 32'hA1);
    check("stall_aluctl", 32'(Alu_Control), 32'b001);
    check("stall_wreg",   32'(WriteReg_E), 32'd3);
    check("stall_memwr",  32'(MemWrite_E), 32'd1);
    Flush_E = 1'b1;
    tick();
    check("flush_valid",  32'(Valid_E), 32'd0);
    check("flush_regwr",  32'(RegWrite_E), 32'd0);
    check("flush_memwr",  32'(MemWrite_E), 32'd0);
    check("flush_aluctl", 32'(Alu_Control), 32'd0);
    Flush_E = 1'b0; Stall_E = 1'b0;

    // non-valid decode slot loads no control
    Valid_D = 1'b0; RegWrite_D = 1'b1; MemWrite_D = 1'b1; Alu_Control_D = 3'b010;
    tick();
    check("nv_valid",  32'(Valid_E), 32'd0);
    check("nv_regwr",  32'(RegWrite_E), 32'd0);
    check("nv_aluctl", 32'(Alu_Control), 32'd0);

    // load-use detection
    Valid_D = 1'b1; MemtoReg_D = 1'b1; MemWrite_D = 1'b0; RegWrite_D = 1'b1;
    Rs_D = 5'd1; Rt_D = 5'd4; RegDst_D = 1'b0;
    tick();
    check("lu_memtoreg", 32'(MemtoReg_E), 32'd1);
    Rs_D = 5'd4; Rt_D = 5'd0;
    settle();
    check("lu_rs_hit", 32'(LoadUse_Stall), 32'd1);
    Rs_D = 5'd5; Rt_D = 5'd6;
    settle();
    check("lu_miss", 32'(LoadUse_Stall), 32'd0);
    Rt_D = 5'd4;
    settle();
    check("lu_rt_hit", 32'(LoadUse_Stall), 32'd1);
    Valid_D = 1'b0;
    settle();
    check("lu_dec_invalid", 32'(LoadUse_Stall), 32'd0);

    // load to r0 still flags a hazard
    Valid_D = 1'b1; Rt_D = 5'd0; Rs_D = 5'd3;
    tick();
    Rs_D = 5'd0; Rt_D = 5'd9;
    settle();
    check("lu_r0", 32'(LoadUse_Stall), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register for the pipelined MIPS core; sits directly upstream of the ALU.
- Captures decoded operands, immediate, register specifiers and control each cycle.
- Resolves EX-stage data hazards by forwarding from MEM and WB, and drives ScrA, ScrB and Alu_Control into the ALU.
- Detects load-use hazards and requests a decode stall.

Parameters:
- width, 32, datapath width (operands, immediate, results)
- addr_w, 5, register specifier width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- Stall_E  in  1  hold current EX contents
- Flush_E  in  1  load a bubble instead of decode contents
- Valid_D  in  1  decode slot holds a real instruction
- RD1_D  in  width  register-file read data A
- RD2_D  in  width  register-file read data B
- SignImm_D  in  width  sign-extended immediate
- Rs_D, Rt_D, Rd_D  in  addr_w each  register specifiers
- RegWrite_D, MemtoReg_D, MemWrite_D, ALUSrc_D, RegDst_D  in  1 each  decoded control
- Alu_Control_D  in  3  ALU operation code
- ALUOut_M  in  width  MEM-stage ALU result
- WriteReg_M  in  addr_w  MEM-stage destination
- RegWrite_M  in  1  MEM-stage write enable
- Result_W  in  width  WB-stage result
- WriteReg_W  in  addr_w  WB-stage destination
- RegWrite_W  in  1  WB-stage write enable
- ScrA  out  width  ALU operand A (forwarded)
- ScrB  out  width  ALU operand B (immediate or forwarded)
- Alu_Control  out  3  ALU operation code
- WriteData_E  out  width  store data (forwarded B)
- WriteReg_E  out  addr_w  destination register
- RegWrite_E, MemtoReg_E, MemWrite_E  out  1 each  control to EX/MEM
- Valid_E  out  1  EX slot holds a real instruction
- LoadUse_Stall  out  1  stall request to fetch/decode

Behaviour:
- Clocking and reset: one clock, clk; rst is synchronous and active-high. When rst is high at a rising edge, all registered fields clear to 0, including Valid_E and all control bits.
- After reset the registered outputs are 0: Alu_Control=3'b000, RegWrite_E=MemtoReg_E=MemWrite_E=0, WriteReg_E=0, LoadUse_Stall=0.
- Forwarded datapath outputs (ScrA, ScrB, WriteData_E) are combinational from registered fields and the M/W inputs, so their value after reset follows those inputs.
- Update priority per edge: rst > Flush_E > Stall_E > load.
  - Flush_E: load a bubble; all fields 0, Valid_E=0. Flush_E wins over a simultaneous Stall_E.
  - Stall_E alone: hold all fields.
  - Otherwise: capture all *_D inputs. If Valid_D=0, the control fields load as 0.
- Latency: 1 cycle from decode inputs to registered fields; the ALU sees operands in the same cycle they are registered.
- Forwarding for A, combinational, first match wins:
  - RegWrite_M && WriteReg_M!=0 && WriteReg_M==Rs_E → ALUOut_M
  - else RegWrite_W && WriteReg_W!=0 && WriteReg_W==Rs_E → Result_W
  - else RD1_E
- Forwarding for B: identical rule using Rt_E and RD2_E.
- Register 0 is never forwarded. MEM has priority over WB because it is the newer value.
- ScrB = ALUSrc_E ? SignImm_E : forwarded B. WriteData_E = forwarded B always.
- WriteReg_E = RegDst_E ? Rd_E : Rt_E.
- Gating: RegWrite_E, MemtoReg_E and MemWrite_E are forced 0 whenever Valid_E=0.
- Load-use: LoadUse_Stall = Valid_E && MemtoReg_E && Valid_D && (Rt_E==Rs_D || Rt_E==Rt_D).
  - Combinational.
  - Rt_E==0 still asserts it (conservative).
  - Not an input to this block's own update logic; the hazard unit converts it into Flush_E plus the upstream stall.
- All arithmetic is pass-through; no width extension is performed. SignImm_D arrives already extended.

Decomposition:
- Shared package holds:
  - ALU op encodings: AND 000, OR 001, ADD 010, SUB 100, MUL 101, SLT 110
  - Forward-select enumeration: FWD_RF, FWD_WB, FWD_MEM
  - width and addr_w defaults
- One natural sub-module, forward_unit: takes the source specifier plus the M/W destinations and enables, returns the forward-select. It is instantiated twice, once for Rs and once for Rt.

Test Plan:
- Reset: assert rst for 2 edges with nonzero D inputs → Valid_E=0, Alu_Control=000, RegWrite_E=0, WriteReg_E=0, LoadUse_Stall=0.
- Plain load: RD1_D=5, RD2_D=7, Alu_Control_D=010, ALUSrc_D=0, RegDst_D=1, Rd_D=9, no M/W writes → next cycle ScrA=5, ScrB=7, Alu_Control=010, WriteReg_E=9.
- Forward priority: Rs_E=3, RegWrite_M=1/WriteReg_M=3/ALUOut_M=0x11, RegWrite_W=1/WriteReg_W=3/Result_W=0x22 → ScrA=0x11. Drop RegWrite_M → ScrA=0x22. Set WriteReg_M=0 with RegWrite_M=1 and WB not matching → ScrA=RD1_E.
- Immediate and store: ALUSrc_D=1, SignImm_D=0xFFFFFFFC, Rt matches WriteReg_W with Result_W=0x40 → ScrB=0xFFFFFFFC, WriteData_E=0x40.
- Stall/flush: load instruction A, then Stall_E=1 for 2 cycles → fields unchanged. Then Flush_E=1 and Stall_E=1 together → Valid_E=0, RegWrite_E=0, MemWrite_E=0.
- Load-use: EX holds MemtoReg=1, Rt_E=4, Valid_E=1; decode presents Rs_D=4 with Valid_D=1 → LoadUse_Stall=1. Change Rs_D=5 and Rt_D=6 → LoadUse_Stall=0.
